// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: hands the shared byte serialiser to one frame source per frame.
// Build option: define TX_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority instead of round-robin.
module tx_frame_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [3*NUM_SRC-1:0]   src_data_bits,
    output logic [NUM_SRC-1:0]     src_req,
    output logic [7:0]             ser_data,
    output logic [2:0]             ser_data_bits,
    output logic                   ser_data_valid,
    input  logic                   ser_req,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [CW-1:0] gap_q, gap_d;
    logic [IW-1:0] pick;
    logic          any_valid;
    logic          sel_valid;
    logic [7:0]    sel_data;
    logic [2:0]    sel_bits;

    assign any_valid = |src_valid;
    assign busy      = (state_q != S_IDLE);

`ifdef TX_ARB_FIXED_PRIORITY_EN
    always_comb begin
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) pick = IW'(i);
        end
    end
`else
    logic [IW-1:0] rr_q;
    logic [IW-1:0] rr_next;
    logic [IW-1:0] rr_idx;
    logic          rr_found;
    int            rr_pos;

    // Scan upwards from rr_ptr, wrapping past the last source.
    always_comb begin
        pick     = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_pos   = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rr_pos = int'(rr_q) + i;
            if (rr_pos >= NUM_SRC) rr_pos = rr_pos - NUM_SRC;
            rr_idx = IW'(rr_pos);
            if (!rr_found && src_valid[rr_idx]) begin
                pick     = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_next = (int'(pick) == NUM_SRC - 1) ? '0 : pick + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else if (state_q == S_IDLE && any_valid) begin
            rr_q <= rr_next;
        end
    end
`endif

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_bits  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gidx_q == IW'(i)) begin
                sel_valid = src_valid[i];
                sel_data  = src_data[8*i +: 8];
                sel_bits  = src_data_bits[3*i +: 3];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (busy) grant[gidx_q] = 1'b1;
    end

    assign ser_data      = busy ? sel_data : '0;
    assign ser_data_bits = busy ? sel_bits : '0;

    always_comb begin
        state_d        = state_q;
        gidx_d         = gidx_q;
        gap_d          = gap_q;
        src_req        = '0;
        ser_data_valid = 1'b0;
        frame_done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    gidx_d  = pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                // A request in the frame's final cycle is still forwarded.
                src_req = ser_req ? grant : '0;
                if (sel_valid) begin
                    ser_data_valid = 1'b1;
                end else begin
                    frame_done = 1'b1;
                    gap_d      = CW'(GAP_CYCLES - 1);
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed frames from three queued sources, checked
// every cycle against a cycle-count model of grant, frame and gap timing.
module tb_tx_frame_arbiter;

    localparam int NS = 3;
    localparam int G  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0][7:0]   sdat;
    logic [NS-1:0][2:0]   sbitv;
    logic [NS-1:0]        src_req;
    logic [7:0]           ser_data;
    logic [2:0]           ser_data_bits;
    logic                 ser_data_valid;
    logic                 ser_req;
    logic [NS-1:0]        grant;
    logic                 busy;
    logic                 frame_done;

    tx_frame_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(G)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_data      (sdat),
        .src_data_bits (sbitv),
        .src_req       (src_req),
        .ser_data      (ser_data),
        .ser_data_bits (ser_data_bits),
        .ser_data_valid(ser_data_valid),
        .ser_req       (ser_req),
        .grant         (grant),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int pass = 0;
    int total = 0;

    logic [7:0]    sq [NS][$];
    logic [2:0]    sbits [NS];
    logic [NS-1:0] last_req = '0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    endtask

    // Sources: valid while bytes remain; a byte is consumed after its req.
    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            src_valid[i] = (sq[i].size() != 0);
            sdat[i]      = (sq[i].size() != 0) ? sq[i][0] : 8'h00;
            sbitv[i]     = sbits[i];
        end
    endtask

    task automatic cyc(input logic req, input int kill = -1);
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (last_req[i] && sq[i].size() != 0) void'(sq[i].pop_front());
        end
        if (kill >= 0) sq[kill].delete();
        drive();
        ser_req = req;
    endtask

    function automatic bit anyq();
        for (int i = 0; i < NS; i++) if (sq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int  n;
        bit  tog;
        n   = 0;
        tog = 1'b0;
        while ((busy || anyq()) && n < budget) begin
            tog = ~tog;
            cyc(tog);
            #1;
            n++;
        end
        total++;
        if (n < budget) pass++;
        else $display("FAIL drain timeout: ran %0d cycles, limit %0d", n, budget);
        cyc(0);
    endtask

    // Reference: owner index, whether its GRANT cycle is next, frame end, gap left.
    int m_own = -1;
    bit m_first = 1'b0;
    bit m_end = 1'b0;
    int m_gap = 0;
    int m_rr = 0;

    function automatic int pick(input logic [NS-1:0] v, input int rr);
        int base;
        base = rr;
`ifdef TX_ARB_FIXED_PRIORITY_EN
        base = 0;
`endif
        for (int k = 0; k < NS; k++) if (v[(base + k) % NS]) return (base + k) % NS;
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NS-1:0] eg, er;
        logic          ev, efd, eb;
        logic [7:0]    ed;
        logic [2:0]    ebits;
        last_req = src_req;
        eg = '0; er = '0; ev = 0; efd = 0; eb = 0; ed = '0; ebits = '0;
        if (rst) begin
            m_own = -1;
            m_rr  = 0;
        end else if (m_own < 0) begin
            if (|src_valid) begin
                m_own   = pick(src_valid, m_rr);
                m_rr    = (m_own + 1) % NS;
                m_first = 1'b1;
                m_end   = 1'b0;
            end
        end else begin
            eb        = 1'b1;
            eg[m_own] = 1'b1;
            ed        = sdat[m_own];
            ebits     = sbitv[m_own];
            if (m_first) begin
                m_first = 1'b0;
            end else if (!m_end) begin
                ev        = src_valid[m_own];
                er[m_own] = ser_req;
                efd       = !ev;
                if (!ev) begin
                    m_end = 1'b1;
                    m_gap = G;
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_own = -1;
            end
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(eb));
        chk("src_req", 32'(src_req), 32'(er));
        chk("ser_data_valid", 32'(ser_data_valid), 32'(ev));
        chk("frame_done", 32'(frame_done), 32'(efd));
        chk("ser_data", 32'(ser_data), 32'(ed));
        chk("ser_data_bits", 32'(ser_data_bits), 32'(ebits));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit tog;
        rst     = 1'b1;
        ser_req = 1'b0;
        for (int i = 0; i < NS; i++) sbits[i] = 3'd0;
        drive();
        repeat (2) cyc(0);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(ser_data_valid), 0);
        chk("rst_done", 32'(frame_done), 0);
        cyc(0);
        rst = 1'b0;
        cyc(0);

        // Two sources contend with rr_ptr at 0.
        sq[0] = '{8'h11, 8'h22};
        sq[1] = '{8'h33};
        cyc(0); #1;
        chk("contest_idle", 32'(grant), 0);
        cyc(0); #1;
        chk("contest_grant", 32'(grant), 32'b001);
        chk("grant_cycle_valid", 32'(ser_data_valid), 0);
        cyc(1); #1;
        chk("active_data", 32'(ser_data), 32'h11);
        chk("active_req", 32'(src_req), 32'b001);
        n = 0;
        tog = 1'b0;
        while (!frame_done && n < 20) begin
            tog = ~tog;
            cyc(tog);
            #1;
            n++;
        end
        chk("frame_done_seen", 32'(frame_done), 1);
        cyc(0);
        cyc(0); #1;
        chk("gap_keeps_grant", 32'(grant), 32'b001);
        cyc(0); #1;
        chk("gap_released", 32'(grant), 0);
        cyc(0); #1;
        chk("second_grant", 32'(grant), 32'b010);
        drain(100);

        sq[0] = '{8'h44};
        sq[1] = '{8'h55};
        cyc(0); cyc(0); #1;
        chk("rr_wrap_contest", 32'(grant), 32'b001);
        drain(100);

        // Lone top-index requester.
        sq[2]    = '{8'h66, 8'h77};
        sbits[2] = 3'd5;
        cyc(0); cyc(0); #1;
        chk("src2_grant", 32'(grant), 32'b100);
        cyc(0); #1;
        chk("src2_bits", 32'(ser_data_bits), 5);
        chk("src2_data", 32'(ser_data), 32'h66);
        drain(100);
        sbits[2] = 3'd0;

        sq[0] = '{8'h88};
        cyc(0); cyc(0); #1;
        chk("single_src0", 32'(grant), 32'b001);
        drain(100);

        sq[0] = '{8'h99};
        sq[2] = '{8'hAA};
        cyc(0); cyc(0); #1;
`ifdef TX_ARB_FIXED_PRIORITY_EN
        chk("policy_contest", 32'(grant), 32'b001);
`else
        chk("policy_contest", 32'(grant), 32'b100);
`endif
        drain(100);

        // Short frame: valid drops together with the only request.
        sq[1]    = '{8'h26};
        sbits[1] = 3'd7;
        cyc(0); cyc(0); cyc(0); #1;
        chk("short_bits", 32'(ser_data_bits), 7);
        chk("short_data", 32'(ser_data), 32'h26);
        cyc(1, 1); #1;
        chk("short_req", 32'(src_req), 32'b010);
        chk("short_done", 32'(frame_done), 1);
        sbits[1] = 3'd0;
        cyc(1); #1;
        chk("gap_req_ignored", 32'(src_req), 0);
        cyc(1); #1;
        chk("gap_req_ignored2", 32'(src_req), 0);
        cyc(1); #1;
        chk("idle_req_ignored", 32'(src_req), 0);
        chk("idle_no_valid", 32'(ser_data_valid), 0);
        cyc(0);

        // Reset in the middle of a frame.
        sq[0] = '{8'hB1, 8'hB2, 8'hB3};
        cyc(0); cyc(0); cyc(0); #1;
        chk("pre_rst_active", 32'(ser_data_valid), 1);
        sq[1] = '{8'hC1};
        cyc(1);
        rst = 1'b1;
        sq[0].delete();
        drive();
        #1;
        chk("rst_async_grant", 32'(grant), 0);
        chk("rst_async_valid", 32'(ser_data_valid), 0);
        chk("rst_async_req", 32'(src_req), 0);
        cyc(0);
        rst = 1'b0;
        #1;
        chk("post_rst_done", 32'(frame_done), 0);
        cyc(0); #1;
        chk("post_rst_grant", 32'(grant), 32'b010);
        chk("post_rst_done2", 32'(frame_done), 0);
        drain(100);

        repeat (2) cyc(0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
